// File: rtl/vector_ls_sequencer.sv
// vector_ls_sequencer: steps a scalar-LSU vector load/store through one word per memory beat, driving slice/word selects.
module vector_ls_sequencer #(
  parameter int NUM_SLICES  = 1,
  parameter int NUM_ELEMS   = 8,
  parameter int ELEM_SIZE   = 16,
  parameter int SCALAR_SIZE = 32,
  localparam int NSPV        = NUM_ELEMS * ELEM_SIZE / SCALAR_SIZE,
  localparam int EPW         = SCALAR_SIZE / ELEM_SIZE,
  localparam int NUM_SCALARS = NSPV * NUM_SLICES,
  localparam int CW          = $clog2(NUM_SCALARS) + 1,
  localparam int SW          = ($clog2(NSPV) < 1) ? 1 : $clog2(NSPV)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_op,
  input  logic [CW-1:0]         count,
  input  logic                  we,
  input  logic                  mem_ack,
  output logic [NUM_ELEMS-1:0]  load_en,
  output logic [NUM_SLICES-1:0] load_slice,
  output logic [SW-1:0]         sel_word,
  output logic [SW-1:0]         sel_store_word,
  output logic [NUM_SLICES-1:0] serial_output,
  output logic                  busy,
  output logic                  complete
);
  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] idx_q, idx_d, last_q, last_d, clamp, slice_i, word_i;
  logic ld, st;
  always_comb begin
    clamp   = (count > CW'(NUM_SCALARS)) ? CW'(NUM_SCALARS) : count;
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (state_q == IDLE && new_op) begin
      last_d  = clamp;
      idx_d   = '0;
      state_d = (clamp == '0) ? DONE : we ? STORE : LOAD;
    end else if ((state_q == LOAD || state_q == STORE) && mem_ack) begin
      idx_d   = idx_q + 1'b1;
      state_d = (idx_q == last_q - 1'b1) ? DONE : state_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end
  // Beat decode: slice-major ordering of scalar words.
  always_comb begin
    ld             = state_q == LOAD;
    st             = state_q == STORE;
    slice_i        = idx_q / CW'(NSPV);
    word_i         = idx_q % CW'(NSPV);
    busy           = state_q != IDLE;
    complete       = state_q == DONE;
    sel_word       = ld ? SW'(word_i) : '0;
    sel_store_word = st ? SW'(word_i) : '0;
    load_slice     = ld ? NUM_SLICES'(1) << slice_i : '0;
    serial_output  = st ? NUM_SLICES'(1) << slice_i : '0;
    for (int e = 0; e < NUM_ELEMS; e++)
      load_en[e] = ld && mem_ack && CW'(e / EPW) == word_i;
  end
endmodule

// File: tb/tb_vector_ls_sequencer.sv
// tb_vector_ls_sequencer: scoreboard bench for vector_ls_sequencer with NUM_SLICES=2 (NSPV=4, EPW=2, 8 scalars).
module tb_vector_ls_sequencer;
  logic clk = 0, reset = 1, new_op = 0, we = 0, mem_ack = 0;
  logic [3:0] count = 0;
  logic [7:0] load_en;
  logic [1:0] load_slice, sel_word, sel_store_word, serial_output;
  logic busy, complete;
  int checks = 0, failures = 0;
  bit mon_on = 0;

  typedef struct packed {
    logic [7:0] en;
    logic [1:0] ls, sw, ssw, so;
    logic busy, cmp;
  } exp_t;
  exp_t sb[$];

  vector_ls_sequencer #(.NUM_SLICES(2)) dut (
    .clk(clk), .reset(reset), .new_op(new_op), .count(count), .we(we), .mem_ack(mem_ack),
    .load_en(load_en), .load_slice(load_slice), .sel_word(sel_word), .sel_store_word(sel_store_word),
    .serial_output(serial_output), .busy(busy), .complete(complete));

  always #5 clk = ~clk;

  function automatic exp_t beat(input bit st, input int b, input bit ack);
    exp_t e = '0;
    logic [7:0] pair = 8'h03;
    e.busy = 1;
    if (st) begin
      e.ssw = 2'(b % 4);
      e.so  = 2'(1 << (b / 4));
    end else begin
      e.sw = 2'(b % 4);
      e.ls = 2'(1 << (b / 4));
      e.en = ack ? pair << (2 * (b % 4)) : 8'h00;
    end
    return e;
  endfunction

  function automatic exp_t done_exp();
    exp_t e = '0;
    e.busy = 1;
    e.cmp  = 1;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t act, e;
    act = {load_en, load_slice, sel_word, sel_store_word, serial_output, busy, complete};
    if (mon_on && (sb.size() > 0 || act != '0)) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output actual=%h required=0", act);
      end else begin
        e = sb.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL beat_outputs actual=%h required=%h", act, e);
        end
      end
    end
  end

  task automatic run_op(input logic [3:0] cnt, input bit st, input int stall_at, input int stall_n,
                        input bit poke, input int rst_at);
    int n = (cnt > 8) ? 8 : int'(cnt);
    new_op = 1; count = cnt; we = st; mem_ack = 1;
    @(posedge clk); #1;
    new_op = 0; count = 4'hF; we = ~st;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < ((b == stall_at) ? stall_n : 0); k++) begin
        mem_ack = 0;
        sb.push_back(beat(st, b, 0));
        @(posedge clk); #1;
      end
      mem_ack = 1;
      sb.push_back(beat(st, b, 1));
      if (poke && b == 1) new_op = 1;
      if (b == rst_at) reset = 1;
      @(posedge clk); #1;
      new_op = 0;
      if (b == rst_at) begin
        reset = 0;
        return;
      end
    end
    sb.push_back(done_exp());
    if (poke) new_op = 1;
    @(posedge clk); #1;
    new_op = 0;
  endtask

  task automatic drain(input string name);
    @(posedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drained actual_pending=%0d required=0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    reset = 1; mem_ack = 1;
    repeat (3) @(posedge clk);
    #1 new_op = 1; count = 4; we = 0;
    @(posedge clk); #1;
    reset = 0; new_op = 0;
    @(negedge clk);
    checks++;
    if ({load_en, load_slice, sel_word, sel_store_word, serial_output, busy, complete} != '0) begin
      failures++;
      $display("FAIL reset_outputs actual=%h required=0",
               {load_en, load_slice, sel_word, sel_store_word, serial_output, busy, complete});
    end
    mon_on = 1;
    @(posedge clk); #1;
    run_op(4, 0, -1, 0, 0, -1);   drain("load4");
    run_op(8, 1, -1, 0, 0, -1);   drain("store8");
    run_op(3, 0, 1, 2, 0, -1);    drain("load3_stall");
    run_op(0, 0, -1, 0, 0, -1);   drain("count0");
    run_op(15, 0, -1, 0, 0, -1);  drain("clamp15");
    run_op(4, 0, -1, 0, 1, -1);   drain("poke_ignored");
    run_op(8, 1, -1, 0, 0, 2);    drain("store_reset");
    repeat (3) @(posedge clk);
    #1;
    run_op(5, 1, 4, 1, 0, -1);    drain("after_reset");
    run_op(6, 0, 0, 1, 0, -1);    drain("load6_stall0");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
